// File: rtl/cdm_video_pkg.sv
// Shared video definitions for the CDM16 display path: default 640x480@60 timing,
// the 12-bit colour type and the RGB565 -> RGB444 field slice.
package cdm_video_pkg;

    localparam int DEF_CLK_DIV     = 4;
    localparam int DEF_H_ACTIVE    = 640;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 96;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 480;
    localparam int DEF_V_FP        = 10;
    localparam int DEF_V_SYNC      = 2;
    localparam int DEF_V_BP        = 33;
    localparam int DEF_SCALE_SHIFT = 2;
    localparam logic [15:0] DEF_FB_BASE = 16'h0000;

    // Wide enough for any pixel/line count up to 4095.
    localparam int CNT_W = 12;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    // Keep the top four bits of each RGB565 field.
    function automatic rgb12_t rgb565_to_rgb12(input logic [15:0] d);
        rgb12_t c;
        c.r = d[15:12];
        c.g = d[10:7];
        c.b = d[4:1];
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick divider plus horizontal/vertical counters; publishes the position the
// counters are moving to on this tick and the sync/origin state of the current pixel.
module vga_timing
    import cdm_video_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
)
(
    input  logic             clock,
    input  logic             reset,
    output logic             tick,
    output logic [CNT_W-1:0] h_nxt,
    output logic [CNT_W-1:0] v_nxt,
    output logic             nxt_active,
    output logic             cur_hs_n,
    output logic             cur_vs_n,
    output logic             frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        div_d = div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        tick  = (div_q == DIV_LAST);
        if (tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // The fetch for a pixel is issued on the tick that moves the counters onto it.
    assign h_nxt      = h_d;
    assign v_nxt      = v_d;
    assign nxt_active = (h_d < H_ACT) && (v_d < V_ACT);
    assign cur_hs_n   = !((h_q >= HS_BEG) && (h_q < HS_END));
    assign cur_vs_n   = !((v_q >= VS_BEG) && (v_q < VS_END));
    assign frame_tick = tick && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vram_scanout.sv
// VGA scanout: fetches RGB565 words from VRAM with pixel/line replication and drives
// 12-bit colour plus active-low syncs one pixel behind the timing counters.
module vram_scanout
    import cdm_video_pkg::*;
#(
    parameter int          CLK_DIV     = DEF_CLK_DIV,
    parameter int          H_ACTIVE    = DEF_H_ACTIVE,
    parameter int          H_FP        = DEF_H_FP,
    parameter int          H_SYNC      = DEF_H_SYNC,
    parameter int          H_BP        = DEF_H_BP,
    parameter int          V_ACTIVE    = DEF_V_ACTIVE,
    parameter int          V_FP        = DEF_V_FP,
    parameter int          V_SYNC      = DEF_V_SYNC,
    parameter int          V_BP        = DEF_V_BP,
    parameter int          SCALE_SHIFT = DEF_SCALE_SHIFT,
    parameter logic [15:0] FB_BASE     = DEF_FB_BASE,
    parameter logic [15:0] FB_WIDTH    = 16'(H_ACTIVE >> SCALE_SHIFT)
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] vram_rd_addr,
    output logic        vram_rd_en,
    input  logic [15:0] vram_rd_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] SCALE_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);

    logic             tick;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    logic             nxt_active, cur_hs_n, cur_vs_n, frame_tick;

    vga_timing #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock      (clock),
        .reset      (reset),
        .tick       (tick),
        .h_nxt      (h_nxt),
        .v_nxt      (v_nxt),
        .nxt_active (nxt_active),
        .cur_hs_n   (cur_hs_n),
        .cur_vs_n   (cur_vs_n),
        .frame_tick (frame_tick)
    );

    logic [15:0] row_base_q, row_base_d;
    logic [15:0] addr_q, addr_d;
    logic        rd_en_q, rd_en_d;
    logic        data_pend_q, data_pend_d;
    logic [15:0] pix_q, pix_d;
    logic        fetch_vld_q, fetch_vld_d;
    rgb12_t      rgb_q, rgb_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic        fetch_go;

    always_comb begin
        // Row base steps by one framebuffer row every 2^SCALE_SHIFT lines.
        row_base_d = row_base_q;
        if (tick && (h_nxt == '0)) begin
            if (v_nxt == '0) begin
                row_base_d = FB_BASE;
            end else if ((v_nxt & SCALE_MASK) == '0) begin
                row_base_d = row_base_q + FB_WIDTH;
            end
        end

        fetch_go    = tick && nxt_active && enable;
        addr_d      = fetch_go ? (row_base_d + 16'(h_nxt >> SCALE_SHIFT)) : addr_q;
        rd_en_d     = fetch_go;
        data_pend_d = rd_en_q;
        pix_d       = data_pend_q ? vram_rd_data : pix_q;
        fetch_vld_d = tick ? fetch_go : fetch_vld_q;

        // Output stage shows the pixel whose counter slot is ending on this tick.
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        if (tick) begin
            rgb_d = fetch_vld_q ? rgb565_to_rgb12(pix_q) : '0;
            hs_d  = cur_hs_n;
            vs_d  = cur_vs_n;
        end
        fs_d = frame_tick;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_base_q  <= FB_BASE;
            addr_q      <= FB_BASE;
            rd_en_q     <= 1'b0;
            data_pend_q <= 1'b0;
            pix_q       <= '0;
            fetch_vld_q <= 1'b0;
            rgb_q       <= '0;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            fs_q        <= 1'b0;
        end else begin
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            data_pend_q <= data_pend_d;
            pix_q       <= pix_d;
            fetch_vld_q <= fetch_vld_d;
            rgb_q       <= rgb_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
        end
    end

    assign vram_rd_addr = addr_q;
    assign vram_rd_en   = rd_en_q;
    assign vga_r        = rgb_q.r;
    assign vga_g        = rgb_q.g;
    assign vga_b        = rgb_q.b;
    assign vga_hs       = hs_q;
    assign vga_vs       = vs_q;
    assign frame_start  = fs_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout on a shrunken raster; expectations are derived per clock
// from the pixel index since reset release using plain arithmetic.
module tb_vram_scanout;

    localparam int CLK_DIV     = 4;
    localparam int H_ACTIVE    = 16;
    localparam int H_FP        = 2;
    localparam int H_SYNC      = 3;
    localparam int H_BP        = 3;
    localparam int V_ACTIVE    = 8;
    localparam int V_FP        = 1;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 1;
    localparam int SCALE_SHIFT = 2;
    localparam logic [15:0] FB_BASE = 16'hFFFA;
    localparam int FBW   = H_ACTIVE >> SCALE_SHIFT;
    localparam int HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME = HT * VT;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] vram_rd_addr;
    logic        vram_rd_en;
    logic [15:0] vram_rd_data;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;

    logic [15:0] mem [0:65535];
    bit          fetched [int];
    int          k;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;
    int          total_cnt = 0;

    always #5 clock = ~clock;

    vram_scanout #(
        .CLK_DIV     (CLK_DIV),
        .H_ACTIVE    (H_ACTIVE),
        .H_FP        (H_FP),
        .H_SYNC      (H_SYNC),
        .H_BP        (H_BP),
        .V_ACTIVE    (V_ACTIVE),
        .V_FP        (V_FP),
        .V_SYNC      (V_SYNC),
        .V_BP        (V_BP),
        .SCALE_SHIFT (SCALE_SHIFT),
        .FB_BASE     (FB_BASE),
        .FB_WIDTH    (16'(FBW))
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .vram_rd_addr (vram_rd_addr),
        .vram_rd_en   (vram_rd_en),
        .vram_rd_data (vram_rd_data),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .frame_start  (frame_start)
    );

    function automatic bit is_active(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return (h < H_ACTIVE) && (v < V_ACTIVE);
    endfunction

    // Framebuffer word for raster pixel p: base + (v/scale)*width + h/scale, mod 2^16.
    function automatic logic [15:0] addr_of(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return 16'(int'(FB_BASE) + (v >> SCALE_SHIFT) * FBW + (h >> SCALE_SHIFT));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_rd_en", 16'(vram_rd_en), 16'd0);
        chk("rst_rd_addr", vram_rd_addr, FB_BASE);
        chk("rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'd0);
        chk("rst_hs", 16'(vga_hs), 16'd1);
        chk("rst_vs", 16'(vga_vs), 16'd1);
        chk("rst_frame_start", 16'(frame_start), 16'd0);
    endtask

    // One clock: VRAM model answers the previous strobe, then every output is checked.
    task automatic step();
        logic        en_pre, rst_pre, rd_pre;
        logic [15:0] a_pre, w;
        logic [11:0] exp_rgb;
        int          p, q, h, v;
        bit          exp_hs, exp_vs, exp_fs;
        en_pre  = enable;
        rst_pre = reset;
        rd_pre  = vram_rd_en;
        a_pre   = vram_rd_addr;
        @(posedge clock);
        #1;
        vram_rd_data = rd_pre ? mem[a_pre] : 16'($urandom);
        if (rst_pre) begin
            k = 0;
            fetched.delete();
            chk_reset_state();
        end else begin
            k++;
            p = k / CLK_DIV;
            if (k % CLK_DIV == 0) begin
                fetched[p] = en_pre && is_active(p);
                chk("rd_en", 16'(vram_rd_en), 16'(fetched[p]));
                if (fetched[p]) chk("rd_addr", vram_rd_addr, addr_of(p));
            end else begin
                chk("rd_en_idle", 16'(vram_rd_en), 16'd0);
            end
            if (p == 0) begin
                chk("pre_tick_rgb", 16'({vga_r, vga_g, vga_b}), 16'd0);
                chk("pre_tick_hs", 16'(vga_hs), 16'd1);
                chk("pre_tick_vs", 16'(vga_vs), 16'd1);
                chk("pre_tick_fs", 16'(frame_start), 16'd0);
            end else begin
                q = p - 1;
                h = q % HT;
                v = (q / HT) % VT;
                exp_rgb = '0;
                if (fetched.exists(q) && fetched[q]) begin
                    w = mem[addr_of(q)];
                    exp_rgb = {w[15:12], w[10:7], w[4:1]};
                end
                exp_hs = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
                exp_vs = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
                exp_fs = (k % CLK_DIV == 0) && (q % FRAME == 0);
                chk("rgb", 16'({vga_r, vga_g, vga_b}), 16'(exp_rgb));
                chk("hs", 16'(vga_hs), 16'(exp_hs));
                chk("vs", 16'(vga_vs), 16'(exp_vs));
                chk("frame_start", 16'(frame_start), 16'(exp_fs));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        // Pure red, green and blue in the first three framebuffer words.
        mem[FB_BASE]         = 16'hF800;
        mem[FB_BASE + 16'd1] = 16'h07E0;
        mem[FB_BASE + 16'd2] = 16'h001F;

        reset        = 1'b1;
        enable       = 1'b1;
        vram_rd_data = 16'h0000;
        k            = 0;
        repeat (5) step();

        reset = 1'b0;
        repeat (FRAME * CLK_DIV + 400) step();

        repeat ($urandom_range(40, 300)) step();
        reset = 1'b1;
        repeat (5) step();
        reset = 1'b0;

        for (int s = 0; s < 12; s++) begin
            enable = 1'($urandom_range(0, 1));
            repeat ($urandom_range(10, 200)) step();
        end

        enable = 1'b0;
        repeat (FRAME * CLK_DIV + 50) step();

        enable = 1'b1;
        repeat (FRAME * CLK_DIV) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vram_scanout.md
# vram_scanout

Video scanout engine for the CDM16 display path: the read-side counterpart of the bus-to-VRAM write path. Generates 640x480@60 VGA timing from the system clock via a pixel-tick divider, fetches RGB565 framebuffer words from the VRAM read port with 4x pixel replication, and drives 12-bit RGB plus sync to the board connector. Sits beside the CPU wrapper; shares only VRAM (dual-port) with the writer.

## Interface
- CLK_DIV, 4: system clocks per pixel; must be >= 3.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal timing in pixels.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical timing in lines.
- SCALE_SHIFT, 2: log2 pixel/line replication.
- FB_BASE, 16'h0000: VRAM word address of pixel (0,0).
- FB_WIDTH, 160: framebuffer words per row (H_ACTIVE >> SCALE_SHIFT).

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- enable  in  1  scanout enable; 0 = no VRAM reads, black output, syncs keep running.
- vram_rd_addr  out  16  VRAM word address.
- vram_rd_en  out  1  read strobe; data valid on vram_rd_data the next cycle.
- vram_rd_data  in  16  RGB565 word.
- vga_r / vga_g / vga_b  out  4 each  colour.
- vga_hs / vga_vs  out  1  syncs, active-low.
- frame_start  out  1  one-clock pulse at start of each frame.

## Operation
- Tick divider counts 0..CLK_DIV-1; pixel tick when divider == CLK_DIV-1.
- On tick: h_count 0..799 wraps to 0 and advances v_count 0..524, which wraps to 0.
- HS low for h in [656,752); VS low for v in [490,492); active = h<640 && v<480.
- Address: row_base + (h >> SCALE_SHIFT). row_base = FB_BASE at v=0; += FB_WIDTH when v advances to a line with low SCALE_SHIFT bits == 0. No multiplier. Sums wrap mod 2^16.
- Fetch: on tick with active && enable, register vram_rd_addr; vram_rd_en high for exactly the following clock; data captured the clock after that into pixel register.
- Output stage: on next tick, pixel register (or 0 when not active/enable) drives RGB; hs/vs/active delayed one pixel to stay aligned.
- Colour map: r = d[15:12], g = d[10:7], b = d[4:1].
- frame_start: pulses on the clock the output stage enters pixel (0,0).
- enable changes take effect at the next tick; no partial pixels.

## Timing
- Reset values: vga_r/g/b = 0, vga_hs = vga_vs = 1, vram_rd_en = 0, vram_rd_addr = FB_BASE, frame_start = 0; divider, counters, row_base cleared; pipeline valid bits cleared.
- Reset mid-frame: next clock restarts at (0,0); first tick one CLK_DIV period after reset release.
- Latency: counters -> output pins = 1 pixel (CLK_DIV clocks); VRAM read occupies clocks 1-2 of the pixel, requiring CLK_DIV >= 3.
- Line = 800*CLK_DIV clocks; frame = 420000*CLK_DIV clocks.
- At most one vram_rd_en per pixel tick; vram_rd_en never asserted outside the active region.

## Structure
- Package cdm_video_pkg: default timing constants, rgb565 field slice function, rgb12 struct typedef.
- Sub-module vga_timing: divider, h/v counters, sync/active/tick/frame-start generation; vram_scanout adds fetch pipeline and colour stage.

## Test plan
- Reset: hold reset 5 clocks mid-line -> all outputs at reset values next clock; after release, first HS falling edge exactly 656*4 clocks after first tick.
- Horizontal: CLK_DIV=4 -> vga_hs low 384 clocks, period 3200 clocks; RGB zero for h>=640.
- Vertical: frame period 1,680,000 clocks; vga_vs low 6400 clocks; exactly one frame_start per frame.
- Addressing: FB_BASE=0 -> pixels (0..3,0) read 0x0000, (4,0) reads 0x0001, (0,4) reads 0x00A0, (639,479) reads 0x4AFF; no reads during blanking.
- Colour: VRAM[0]=0xF800 -> first active pixel r=F,g=0,b=0; VRAM[1]=0x07E0 -> g=F; 0x001F -> b=F; each appearing one pixel after its counter position.
- Enable low: vram_rd_en stays 0, RGB 0, hs/vs identical to enabled run; re-enable mid-line -> correct data from next tick.
